pipe_if_stage: RTL

//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined CPU, directly upstream of the ID stage.

---
 rtl/pipe_if_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_if_stage : IF stage with req/ack imem fetch and IF/ID register      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] word;
  logic        redir;
  logic        avail;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir    = wpcir & (pcsource != 2'b00);
  assign avail    = ((state_q == ST_FETCH) & imem_ack) | (state_q == ST_HOLD);
  assign word     = (state_q == ST_HOLD) ? buf_q : imem_rdata;

  always_comb begin
    target = pc_plus4;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dpc4_d      = dpc4_q;
    inst_d      = inst_q;
    dvalid_d    = dvalid_q;
    buf_d       = buf_q;
    drop_addr_d = drop_addr_q;

    if (state_q == ST_DROP) begin
      // The wrong-path request must complete before a new fetch may start.
      if (wpcir) begin
        dpc4_d   = 32'd0;
        inst_d   = 32'd0;
        dvalid_d = 1'b0;
        if (redir) begin
          pc_d = target;
        end
      end
      if (imem_ack) begin
        state_d = ST_FETCH;
      end
    end else if (!wpcir) begin
      if ((state_q == ST_FETCH) && imem_ack) begin
        buf_d   = imem_rdata;
        state_d = ST_HOLD;
      end
    end else if (redir) begin
      pc_d     = target;
      dpc4_d   = 32'd0;
      inst_d   = 32'd0;
      dvalid_d = 1'b0;
      if ((state_q == ST_FETCH) && !imem_ack) begin
        drop_addr_d = pc_q;
        state_d     = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
    end else if (avail) begin
      dpc4_d   = pc_plus4;
      inst_d   = word;
      dvalid_d = 1'b1;
      pc_d     = pc_plus4;
      state_d  = ST_FETCH;
    end else begin
      dpc4_d   = 32'd0;
      inst_d   = 32'd0;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      dpc4_q      <= 32'd0;
      inst_q      <= 32'd0;
      dvalid_q    <= 1'b0;
      buf_q       <= 32'd0;
      drop_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dpc4_q      <= dpc4_d;
      inst_q      <= inst_d;
      dvalid_q    <= dvalid_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem_req  = !reset && (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign pc        = pc_q;
  assign dpc4      = dpc4_q;
  assign inst      = inst_q;
  assign dvalid    = dvalid_q;

endmodule
`default_nettype wire
